// File: rtl/game_tick_pkg.sv
// -----------------------------------------------------------------------------
// game_tick_pkg
//   Shared types and constants for the game tick generator.
//   - tick_state_t : per-channel control state (IDLE / RUN / PAUSE)
//   - CNT_W_DEFAULT: default counter / period width
//   - PER_*        : ready-made periods for a 50 MHz system clock
//   - period_from_hz(): integer period for an arbitrary tick rate
// -----------------------------------------------------------------------------
package game_tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } tick_state_t;

    localparam int CNT_W_DEFAULT = 22;

    localparam int unsigned SYS_CLK_HZ = 50_000_000;

    // Common game rates at 50 MHz. All of these fit in CNT_W_DEFAULT bits.
    localparam int unsigned PER_15HZ  = 3_333_333;
    localparam int unsigned PER_30HZ  = 1_666_667;
    localparam int unsigned PER_60HZ  = 833_333;
    localparam int unsigned PER_120HZ = 416_667;
    localparam int unsigned PER_1KHZ  = 50_000;

    // Rounded-down period for a given tick rate; returns 0 (channel stays
    // idle) for a zero rate rather than dividing by zero.
    function automatic int unsigned period_from_hz(input int unsigned hz);
        if (hz == 0) begin
            return 0;
        end
        return SYS_CLK_HZ / hz;
    endfunction

endpackage

// File: rtl/game_tick_gen_channel.sv
// -----------------------------------------------------------------------------
// tick_channel
//   One tick channel: cycle counter, shadow period register and control FSM.
//   A single-cycle tick is produced every per_q cycles while running, and a
//   square wave toggles on each tick. The shadow period is only refreshed on
//   restart, on start from IDLE and on each wrap, so period writes never cut
//   a count short or stretch it mid-way.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset
//   period_i   : requested period (0 = stop channel at next load)
//   run_i      : 1 = count, 0 = pause (state held)
//   restart_i  : single-cycle restart request (clear count, reload period)
//   tick_o     : registered tick pulse
//   sq_o       : registered square wave, toggles on every tick
//   active_o   : 1 while the channel is in RUN
// -----------------------------------------------------------------------------
module tick_channel
    import game_tick_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CNT_W-1:0] period_i,
    input  logic             run_i,
    input  logic             restart_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic             active_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tick_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [CNT_W-1:0] per_q,   per_d;
    logic             tick_q,  tick_d;
    logic             sq_q,    sq_d;

    logic             period_zero;
    logic             at_wrap;

    assign period_zero = (period_i == CNT_ZERO);
    // per_q is never 0 while counting, so per_q-1 cannot underflow here.
    assign at_wrap     = (cnt_q == (per_q - CNT_ONE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        tick_d  = 1'b0;
        sq_d    = sq_q;

        if (restart_i) begin
            // Restart wins over a coincident wrap: no tick this cycle.
            cnt_d = CNT_ZERO;
            sq_d  = 1'b0;
            per_d = period_i;
            if (period_zero) begin
                state_d = ST_IDLE;
            end else if (run_i) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_PAUSE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (run_i && !period_zero) begin
                        state_d = ST_RUN;
                        per_d   = period_i;
                        cnt_d   = CNT_ZERO;
                    end
                end

                // Resuming from PAUSE counts on the same edge that sees
                // run_i return, so a pause of D cycles costs exactly D cycles.
                ST_RUN, ST_PAUSE: begin
                    if (!run_i) begin
                        state_d = ST_PAUSE;
                    end else begin
                        state_d = ST_RUN;
                        if (at_wrap) begin
                            cnt_d = CNT_ZERO;
                            per_d = period_i;
                            if (period_zero) begin
                                // Wrapping into a zero period stops the
                                // channel; the square output keeps its level.
                                state_d = ST_IDLE;
                            end else begin
                                tick_d = 1'b1;
                                sq_d   = ~sq_q;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            per_q   <= CNT_ZERO;
            tick_q  <= 1'b0;
            sq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            tick_q  <= tick_d;
            sq_q    <= sq_d;
        end
    end

    assign tick_o   = tick_q;
    assign sq_o     = sq_q;
    assign active_o = (state_q == ST_RUN);

endmodule

// File: rtl/game_tick_gen.sv
// -----------------------------------------------------------------------------
// game_tick_gen
//   Multi-channel programmable tick generator. Produces clock enables for the
//   game logic instead of derived clocks; every channel is an independent
//   tick_channel, this level only slices the packed buses.
//
// Parameters
//   NUM_CH : number of channels
//   CNT_W  : counter / period width (>= 2)
//
// Ports
//   clk_50MHz : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   period_i  : packed periods, channel k at [k*CNT_W +: CNT_W]
//   run_i     : per-channel run (1) / pause (0)
//   restart_i : per-channel single-cycle restart
//   tick_o    : per-channel one-cycle tick pulse
//   sq_o      : per-channel square wave (period 2*P)
//   active_o  : per-channel RUN indicator
// -----------------------------------------------------------------------------
module game_tick_gen
    import game_tick_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic                    clk_50MHz,
    input  logic                    rst_n,
    input  logic [NUM_CH*CNT_W-1:0] period_i,
    input  logic [NUM_CH-1:0]       run_i,
    input  logic [NUM_CH-1:0]       restart_i,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       sq_o,
    output logic [NUM_CH-1:0]       active_o
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        tick_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i     (clk_50MHz),
            .rst_ni    (rst_n),
            .period_i  (period_i[gi*CNT_W +: CNT_W]),
            .run_i     (run_i[gi]),
            .restart_i (restart_i[gi]),
            .tick_o    (tick_o[gi]),
            .sq_o      (sq_o[gi]),
            .active_o  (active_o[gi])
        );
    end

endmodule

// File: tb/tb_game_tick_gen.sv
module tb_game_tick_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 22;

    logic                    clk_50MHz = 1'b0;
    logic                    rst_n;
    logic [NUM_CH*CNT_W-1:0] period_i;
    logic [NUM_CH-1:0]       run_i;
    logic [NUM_CH-1:0]       restart_i;
    logic [NUM_CH-1:0]       tick_o;
    logic [NUM_CH-1:0]       sq_o;
    logic [NUM_CH-1:0]       active_o;

    int checks = 0;
    int errors = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    game_tick_gen #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .period_i  (period_i),
        .run_i     (run_i),
        .restart_i (restart_i),
        .tick_o    (tick_o),
        .sq_o      (sq_o),
        .active_o  (active_o)
    );

    // ------------------------------------------------------------------
    // Reference model: a channel is "live" once started; while live and
    // running, it counts elapsed cycles and ticks when elapsed reaches the
    // latched period, then latches the current request.
    // ------------------------------------------------------------------
    typedef struct packed {
        bit live;
        int per;
        int el;
        bit sq;
        bit tk;
        bit act;
    } mst_t;

    mst_t m_q [NUM_CH];
    mst_t m_d [NUM_CH];
    logic [NUM_CH-1:0] exp_tick, exp_sq, exp_act;

    function automatic mst_t next_ch(input mst_t s, input int p, input bit r, input bit rs);
        mst_t n;
        n    = s;
        n.tk = 1'b0;
        if (rs) begin
            n.live = (p != 0);
            n.per  = p;
            n.el   = 0;
            n.sq   = 1'b0;
            n.act  = (p != 0) && r;
        end else if (!s.live) begin
            if (r && p != 0) begin
                n.live = 1'b1;
                n.per  = p;
                n.el   = 0;
                n.act  = 1'b1;
            end else begin
                n.act = 1'b0;
            end
        end else if (!r) begin
            n.act = 1'b0;
        end else begin
            n.act = 1'b1;
            n.el  = s.el + 1;
            if (n.el == s.per) begin
                n.el  = 0;
                n.per = p;
                if (p == 0) begin
                    n.live = 1'b0;
                    n.act  = 1'b0;
                end else begin
                    n.tk = 1'b1;
                    n.sq = ~s.sq;
                end
            end
        end
        return n;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            m_d[k] = next_ch(m_q[k], int'(period_i[k*CNT_W +: CNT_W]), run_i[k], restart_i[k]);
        end
    end

    always_comb begin
        exp_tick = '0;
        exp_sq   = '0;
        exp_act  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            exp_tick[k] = m_q[k].tk;
            exp_sq[k]   = m_q[k].sq;
            exp_act[k]  = m_q[k].act;
        end
    end

    always @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) m_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) m_q[k] <= m_d[k];
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking here)
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk_50MHz);
        @(negedge clk_50MHz);
    endtask

    task automatic set_per(input int k, input int p);
        period_i[k*CNT_W +: CNT_W] = CNT_W'(p);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        period_i  = '0;
        run_i     = '0;
        restart_i = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        period_i  = '0;
        run_i     = '0;
        restart_i = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #5;
        checks++;
        if ({tick_o, sq_o, active_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got t=%b s=%b a=%b exp all 0", tick_o, sq_o, active_o);
        end
        @(negedge clk_50MHz);
        cyc();
        rst_n = 1'b1;
        run_i = '1;           // run with zero periods: everything stays idle
        for (int n = 0; n < 4; n++) begin
            cyc();
            checks++;
            if ({tick_o, sq_o, active_o} !== '0) begin
                errors++;
                $display("FAIL reset_idle n=%0d got t=%b s=%b a=%b exp all 0", n, tick_o, sq_o, active_o);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_periodic();
        do_reset();
        set_per(0, 4);
        run_i[0] = 1'b1;
        cyc();                // start edge
        for (int n = 1; n <= 12; n++) begin
            cyc();
            checks++;
            if (tick_o[0] !== (n % 4 == 0) || sq_o[0] !== ((n / 4) % 2 == 1) || active_o[0] !== 1'b1) begin
                errors++;
                $display("FAIL periodic n=%0d got t=%b s=%b a=%b exp t=%b s=%b a=1",
                         n, tick_o[0], sq_o[0], active_o[0], (n % 4 == 0), ((n / 4) % 2 == 1));
            end
            checks++;
            if ({tick_o, sq_o, active_o} !== {exp_tick, exp_sq, exp_act}) begin
                errors++;
                $display("FAIL model_periodic n=%0d got %b %b %b exp %b %b %b",
                         n, tick_o, sq_o, active_o, exp_tick, exp_sq, exp_act);
            end
        end
        $display("test_periodic done");
    endtask

    task automatic test_period_change();
        do_reset();
        set_per(0, 5);
        run_i[0] = 1'b1;
        cyc();
        for (int n = 1; n <= 16; n++) begin
            if (n == 8) set_per(0, 3);   // count is 2 here
            cyc();
            checks++;
            if (tick_o[0] !== (n == 5 || n == 10 || n == 13 || n == 16)) begin
                errors++;
                $display("FAIL period_change n=%0d got t=%b exp t=%b", n, tick_o[0],
                         (n == 5 || n == 10 || n == 13 || n == 16));
            end
        end
        $display("test_period_change done");
    endtask

    task automatic test_pause();
        do_reset();
        set_per(0, 6);
        run_i[0] = 1'b1;
        cyc();
        for (int n = 1; n <= 24; n++) begin
            if (n == 10) run_i[0] = 1'b0;    // count is 3 here
            if (n == 20) run_i[0] = 1'b1;
            cyc();
            checks++;
            if (tick_o[0] !== (n == 6 || n == 22) || active_o[0] !== !(n >= 10 && n <= 19)) begin
                errors++;
                $display("FAIL pause n=%0d got t=%b a=%b exp t=%b a=%b", n, tick_o[0], active_o[0],
                         (n == 6 || n == 22), !(n >= 10 && n <= 19));
            end
        end
        $display("test_pause done");
    endtask

    task automatic test_restart_wrap();
        do_reset();
        set_per(0, 4);
        run_i[0] = 1'b1;
        cyc();
        for (int n = 1; n <= 13; n++) begin
            restart_i[0] = (n == 8);          // coincides with the wrap edge
            cyc();
            checks++;
            if (tick_o[0] !== (n == 4 || n == 12) || sq_o[0] !== ((n >= 4 && n < 8) || n >= 12)) begin
                errors++;
                $display("FAIL restart_wrap n=%0d got t=%b s=%b exp t=%b s=%b", n, tick_o[0], sq_o[0],
                         (n == 4 || n == 12), ((n >= 4 && n < 8) || n >= 12));
            end
        end
        restart_i[0] = 1'b0;
        $display("test_restart_wrap done");
    endtask

    task automatic test_zero_one();
        do_reset();
        set_per(1, 0);
        set_per(2, 1);
        run_i[1] = 1'b1;
        run_i[2] = 1'b1;
        cyc();
        for (int n = 1; n <= 10; n++) begin
            cyc();
            checks++;
            if (tick_o[1] !== 1'b0 || active_o[1] !== 1'b0) begin
                errors++;
                $display("FAIL zero_period n=%0d got t=%b a=%b exp t=0 a=0", n, tick_o[1], active_o[1]);
            end
            checks++;
            if (tick_o[2] !== 1'b1 || sq_o[2] !== (n % 2 == 1) || active_o[2] !== 1'b1) begin
                errors++;
                $display("FAIL period_one n=%0d got t=%b s=%b a=%b exp t=1 s=%b a=1",
                         n, tick_o[2], sq_o[2], active_o[2], (n % 2 == 1));
            end
        end
        $display("test_zero_one done");
    endtask

    task automatic test_async_reset();
        int pers [NUM_CH];
        int first[NUM_CH];
        pers = '{2, 3, 7, 100};
        do_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            set_per(k, pers[k]);
            first[k] = -1;
        end
        run_i = '1;
        for (int n = 0; n < 40; n++) cyc();
        @(posedge clk_50MHz);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({tick_o, sq_o, active_o} !== '0) begin
            errors++;
            $display("FAIL async_reset got t=%b s=%b a=%b exp all 0", tick_o, sq_o, active_o);
        end
        @(negedge clk_50MHz);
        cyc();
        rst_n = 1'b1;
        cyc();                // start edge for every channel
        for (int n = 1; n <= 110; n++) begin
            cyc();
            for (int k = 0; k < NUM_CH; k++) begin
                if (tick_o[k] === 1'b1 && first[k] < 0) first[k] = n;
            end
            checks++;
            if ({tick_o, sq_o, active_o} !== {exp_tick, exp_sq, exp_act}) begin
                errors++;
                $display("FAIL model_async n=%0d got %b %b %b exp %b %b %b",
                         n, tick_o, sq_o, active_o, exp_tick, exp_sq, exp_act);
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            checks++;
            if (first[k] != pers[k]) begin
                errors++;
                $display("FAIL async_first_tick ch=%0d got %0d exp %0d", k, first[k], pers[k]);
            end
        end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < NUM_CH; k++) set_per(k, $urandom_range(1, 9));
        run_i = '1;
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                restart_i[k] = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 15) == 0) run_i[k] = ~run_i[k];
                if ($urandom_range(0, 19) == 0) set_per(k, $urandom_range(0, 9));
            end
            cyc();
            checks++;
            if ({tick_o, sq_o, active_o} !== {exp_tick, exp_sq, exp_act}) begin
                errors++;
                $display("FAIL model_random n=%0d got %b %b %b exp %b %b %b",
                         n, tick_o, sq_o, active_o, exp_tick, exp_sq, exp_act);
            end
        end
        restart_i = '0;
        $display("test_random done");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_periodic();
        test_period_change();
        test_pause();
        test_restart_wrap();
        test_zero_one();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_tick_gen.md
# game_tick_gen

Multi-channel, runtime-programmable tick generator for the game logic, running in the `clk_50MHz` domain. Each channel produces a single-cycle enable pulse every `period` clock cycles, plus an optional 50 %-style square output. It replaces free-running derived clocks with clock enables, so ball, paddle and animation updates stay synchronous to `clk_50MHz`. Each channel has its own period, run/pause control and restart. Period changes are glitch-free: a new value takes effect only at a wrap or on restart.

## Interface
- `NUM_CH`, default 4: number of independent channels.
- `CNT_W`, default 22: counter and period width; must be ≥ 2.

- `clk_50MHz`, input, 1: system clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `period_i`, input, `NUM_CH*CNT_W`: packed per-channel period; channel k is `[k*CNT_W +: CNT_W]`.
- `run_i`, input, `NUM_CH`: 1 = count; 0 = pause and hold state.
- `restart_i`, input, `NUM_CH`: single-cycle request; clears the counter and loads the period.
- `tick_o`, output, `NUM_CH`: registered pulse, high one cycle per period.
- `sq_o`, output, `NUM_CH`: registered square wave; toggles on every tick.
- `active_o`, output, `NUM_CH`: 1 when the channel is in RUN.

## Operation
- Per-channel state:
  - `cnt` (`CNT_W` bits)
  - shadow period `per_q` (`CNT_W` bits)
  - FSM with states IDLE, RUN, PAUSE
- Reset values:
  - `cnt` = 0, `per_q` = 0, FSM = IDLE
  - `tick_o` = 0, `sq_o` = 0, `active_o` = 0
- Shadow load: `per_q` ← `period_i[k]` on restart, on IDLE→RUN, and on each wrap. Writes to `period_i` at any other time do not affect the current cycle count.
- FSM transitions:
  - IDLE → RUN when `run_i[k]`=1 and `period_i[k]` ≠ 0. This loads `per_q` and sets `cnt`=0.
  - RUN → PAUSE when `run_i[k]`=0. `cnt` and `sq_o` are held.
  - PAUSE → RUN when `run_i[k]`=1. Counting resumes from the held `cnt`, with no reload.
  - Any state → IDLE when the loaded period is 0 (a restart or wrap with `period_i`=0). `sq_o` is held; `tick_o` = 0.
- In RUN:
  - If `cnt` == `per_q`−1: `cnt` ← 0, `tick_o` ← 1, `sq_o` ← ~`sq_o`, and `per_q` reloads.
  - Otherwise: `cnt` ← `cnt`+1, `tick_o` ← 0.
- `restart_i[k]`:
  - Sets `cnt`=0, `sq_o`=0 and `tick_o`=0, and loads `per_q`.
  - Next state is RUN if `run_i[k]`=1, PAUSE if `run_i`=0 (and period ≠ 0); IDLE if the period is 0.
  - Restart has priority over wrap in the same cycle, so no tick is emitted that cycle.
- Period 1: `tick_o` is high every cycle while in RUN, and `sq_o` toggles every cycle.
- Arithmetic: unsigned, modulo 2^`CNT_W`. The compare uses `per_q`−1 computed at `CNT_W` bits; this is safe because `per_q` ≠ 0 in RUN.
- Channels are fully independent. There is no cross-channel interaction.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- First tick after IDLE→RUN or after a restart into RUN: `tick_o` rises on the P-th rising edge after the edge that sampled the start. It is then periodic with period exactly P cycles.
- Pause time is excluded from the count. A channel paused for D cycles delays its next tick by exactly D cycles.
- `sq_o` period is 2·P cycles; high time is P cycles.
- Asynchronous reset mid-count forces all state to reset values immediately. The first count begins on the first edge after `rst_n` deasserts.

## Structure
- Package `game_tick_pkg`:
  - FSM state typedef `tick_state_t` (IDLE/RUN/PAUSE)
  - default `CNT_W`
  - named period constants for the 50 MHz clock, e.g. `PER_60HZ` = 833333
- Sub-module `tick_channel` (one counter, shadow register and FSM), instantiated `NUM_CH` times in a generate loop. The top level only slices the buses.

## Test plan
- P=4, run=1 from reset: `tick_o` high on cycles 4, 8, 12 after start; `sq_o` toggles at the same edges; `active_o`=1.
- P=5, then `period_i` changed to 3 mid-cycle at `cnt`=2: the next tick still comes 5 cycles after the previous one, and ticks are then spaced 3 apart.
- P=6, `run_i` dropped for 10 cycles at `cnt`=3: the next tick comes 13 cycles after the pause began (3 remaining + 10 paused); `active_o`=0 during the pause.
- Restart asserted in the same cycle as a wrap (P=4): no tick that cycle; `sq_o`=0; the next tick comes 4 cycles later.
- `period_i`=0 with run=1: the channel stays IDLE and `tick_o` stays 0. P=1: `tick_o` is constantly 1 and `sq_o` toggles every cycle.
- `rst_n` pulsed low mid-run on 4 channels with P=2, 3, 7, 100: all outputs go 0 immediately; after release each channel restarts and its first tick comes at its own P.
